// File: rtl/nbit_alu_pkg.sv
// Shared constants and types for the serial ALU datapath blocks.
package nbit_alu_pkg;

  // Bit positions inside the 4-bit status flag vector.
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } serial_state_t;

endpackage

// File: rtl/one_bit_full_adder.sv
// Single combinational full-adder cell used by the bit-serial adder.
module one_bit_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum and carry of three input bits.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/nbit_serial_adder.sv
// Bit-serial N-bit two's-complement adder with start/done handshake.
// Optional subtract mode (sub port) is enabled by defining NBIT_SERIAL_ADDER_SUB_EN.
module nbit_serial_adder
  import nbit_alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
`ifdef NBIT_SERIAL_ADDER_SUB_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic [3:0]   flags
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  serial_state_t state_q, state_d;
  logic [N-1:0]  a_sr_q, a_sr_d;
  logic [N-1:0]  b_sr_q, b_sr_d;
  logic [N-1:0]  sum_sr_q, sum_sr_d;
  logic [N-1:0]  result_q, result_d;
  logic [3:0]    flags_q, flags_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cy_q, cy_d;
  logic          cy_prev_q, cy_prev_d;
  logic          sub_q, sub_d;
  logic          sub_w;
  logic          fa_s;
  logic          fa_cout;

`ifdef NBIT_SERIAL_ADDER_SUB_EN
  assign sub_w = sub;
`else
  assign sub_w = 1'b0;
`endif

  one_bit_full_adder u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (cy_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // Next-state, datapath shifting and completion flag computation.
  // Result and flags are loaded on the final RUN edge (from the next-state
  // values) so they are already valid during the single DONE cycle.
  always_comb begin
    state_d   = state_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    sum_sr_d  = sum_sr_q;
    result_d  = result_q;
    flags_d   = flags_q;
    cnt_d     = cnt_q;
    cy_d      = cy_q;
    cy_prev_d = cy_prev_q;
    sub_d     = sub_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d    = a;
          b_sr_d    = sub_w ? ~b : b;
          cy_d      = sub_w;
          cy_prev_d = 1'b0;
          sub_d     = sub_w;
          cnt_d     = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        sum_sr_d  = {fa_s, sum_sr_q[N-1:1]};
        a_sr_d    = a_sr_q >> 1;
        b_sr_d    = b_sr_q >> 1;
        cy_d      = fa_cout;
        cy_prev_d = cy_q;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d           = '0;
          state_d         = DONE;
          result_d        = sum_sr_d;
          flags_d[FLAG_Z] = ~|sum_sr_d;
          flags_d[FLAG_N] = sum_sr_d[N-1];
          flags_d[FLAG_C] = fa_cout ^ sub_q;
          flags_d[FLAG_V] = fa_cout ^ cy_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      sum_sr_q  <= '0;
      result_q  <= '0;
      flags_q   <= '0;
      cnt_q     <= '0;
      cy_q      <= 1'b0;
      cy_prev_q <= 1'b0;
      sub_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      sum_sr_q  <= sum_sr_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      cnt_q     <= cnt_d;
      cy_q      <= cy_d;
      cy_prev_q <= cy_prev_d;
      sub_q     <= sub_d;
    end
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    busy   = (state_q == RUN);
    done   = (state_q == DONE);
    result = result_q;
    flags  = flags_q;
  end

endmodule
